// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - state, opcode and field definitions shared by alu_seq
package alu_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SRC0_DRV,
    SRC0_LAT,
    GAP,
    SRC1_DRV,
    SRC1_LAT,
    EXEC,
    OUT_DRV,
    WB,
    DONE,
    ERR
  } state_e;

  localparam logic [3:0] OPC_ALU_MIN = 4'h8;
  localparam logic [3:0] OPC_ALU_MAX = 4'hE;
  localparam logic [3:0] OPC_ALU_IMM = 4'hF;

  // Opcode occupies the top OPC_W bits of the instruction word.
  localparam int OPC_W = 4;

  function automatic logic is_alu_opc(input logic [3:0] opc);
    return ((opc >= OPC_ALU_MIN) && (opc <= OPC_ALU_MAX)) || (opc == OPC_ALU_IMM);
  endfunction

endpackage

// File: rtl/alu_seq_idx_onehot.sv
// rtl/alu_seq_idx_onehot.sv - register index to MSB-first one-hot enable plus range flag
module idx_onehot #(
  parameter int NUM_REGS = 4,
  parameter int IDX_W    = 6
) (
  input  logic [IDX_W-1:0]    idx_i,
  output logic [NUM_REGS-1:0] onehot_o,
  output logic                in_range_o
);

  always_comb begin
    onehot_o   = '0;
    in_range_o = (32'(idx_i) < NUM_REGS);
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(idx_i) == i) onehot_o[NUM_REGS-1-i] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - ALU instruction sequencer driving register-file and ALU strobes
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int INSTR_W  = 16,
  parameter int IDX_W    = 6,
  parameter int SETTLE   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [INSTR_W-1:0]  instruction,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                pc_inc,
  output logic [NUM_REGS-1:0] rx_out,
  output logic [NUM_REGS-1:0] rx_in,
  output logic                alu_in0,
  output logic                alu_in1,
  output logic                alu_out_latch,
  output logic                alu_out_en,
  output logic                imm_en,
  output logic [IDX_W-1:0]    imm_val
);

  localparam int OPC_LSB = INSTR_W - OPC_W;

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 accept, is_imm, p1_ok, p2_ok;
  logic [IDX_W-1:0]     p1, p2;
  logic [NUM_REGS-1:0]  oh1, oh2;

  logic                 busy_d, done_d, err_d, pc_inc_d;
  logic                 alu_in0_d, alu_in1_d, alu_out_latch_d, alu_out_en_d, imm_en_d;
  logic [NUM_REGS-1:0]  rx_out_d, rx_in_d;
  logic [IDX_W-1:0]     imm_val_d;

  assign accept  = (state_q == IDLE) && start && is_alu_opc(instruction[INSTR_W-1 -: OPC_W]);
  assign instr_d = accept ? instruction : instr_q;
  assign p1      = instr_d[OPC_LSB-1 -: IDX_W];
  assign p2      = instr_d[IDX_W-1:0];
  assign is_imm  = (instr_d[INSTR_W-1 -: OPC_W] == OPC_ALU_IMM);

  // Decoders look at instr_d so the range check and the first output cycle share them.
  idx_onehot #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_p1 (
    .idx_i(p1), .onehot_o(oh1), .in_range_o(p1_ok)
  );
  idx_onehot #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_p2 (
    .idx_i(p2), .onehot_o(oh2), .in_range_o(p2_ok)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:     if (accept) state_d = (p1_ok && (is_imm || p2_ok)) ? SRC0_DRV : ERR;
      SRC0_DRV: state_d = SRC0_LAT;
      SRC0_LAT: state_d = GAP;
      GAP:      state_d = SRC1_DRV;
      SRC1_DRV: state_d = SRC1_LAT;
      SRC1_LAT: begin
        state_d = EXEC;
        cnt_d   = 4'(SETTLE - 1);
      end
      EXEC: begin
        if (cnt_q == 4'd0) state_d = OUT_DRV;
        else               cnt_d   = cnt_q - 4'd1;
      end
      OUT_DRV:  state_d = WB;
      WB:       state_d = DONE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in flops alongside it.
  always_comb begin
    done_d          = 1'b0;
    err_d           = 1'b0;
    pc_inc_d        = 1'b0;
    rx_out_d        = '0;
    rx_in_d         = '0;
    alu_in0_d       = 1'b0;
    alu_in1_d       = 1'b0;
    alu_out_latch_d = 1'b0;
    alu_out_en_d    = 1'b0;
    imm_en_d        = 1'b0;
    case (state_d)
      SRC0_DRV: begin
        pc_inc_d = 1'b1;
        rx_out_d = oh1;
      end
      SRC0_LAT: begin
        rx_out_d  = oh1;
        alu_in0_d = 1'b1;
      end
      SRC1_DRV, SRC1_LAT: begin
        if (is_imm) imm_en_d = 1'b1;
        else        rx_out_d = oh2;
        alu_in1_d = (state_d == SRC1_LAT);
      end
      EXEC:     alu_out_latch_d = 1'b1;
      OUT_DRV:  alu_out_en_d    = 1'b1;
      WB: begin
        alu_out_en_d = 1'b1;
        rx_in_d      = oh1;
      end
      DONE:     done_d = 1'b1;
      ERR: begin
        done_d = 1'b1;
        err_d  = 1'b1;
      end
      default: ;
    endcase
    busy_d    = (state_d != IDLE);
    imm_val_d = busy_d ? p2 : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      instr_q       <= '0;
      cnt_q         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      pc_inc        <= 1'b0;
      rx_out        <= '0;
      rx_in         <= '0;
      alu_in0       <= 1'b0;
      alu_in1       <= 1'b0;
      alu_out_latch <= 1'b0;
      alu_out_en    <= 1'b0;
      imm_en        <= 1'b0;
      imm_val       <= '0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      cnt_q         <= cnt_d;
      busy          <= busy_d;
      done          <= done_d;
      err           <= err_d;
      pc_inc        <= pc_inc_d;
      rx_out        <= rx_out_d;
      rx_in         <= rx_in_d;
      alu_in0       <= alu_in0_d;
      alu_in1       <= alu_in1_d;
      alu_out_latch <= alu_out_latch_d;
      alu_out_en    <= alu_out_en_d;
      imm_en        <= imm_en_d;
      imm_val       <= imm_val_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - bench for alu_seq: two parameterisations against a cycle-timeline model
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] instruction;

  logic       a_busy, a_done, a_err, a_pc_inc, a_alu_in0, a_alu_in1, a_latch, a_out_en, a_imm_en;
  logic [3:0] a_rx_out, a_rx_in;
  logic [5:0] a_imm_val;
  logic       b_busy, b_done, b_err, b_pc_inc, b_alu_in0, b_alu_in1, b_latch, b_out_en, b_imm_en;
  logic [7:0] b_rx_out, b_rx_in;
  logic [5:0] b_imm_val;

  always #5 clk = ~clk;

  alu_seq #(.NUM_REGS(4), .INSTR_W(16), .IDX_W(6), .SETTLE(1)) u_a (
    .clk(clk), .rst(rst), .start(start), .instruction(instruction),
    .busy(a_busy), .done(a_done), .err(a_err), .pc_inc(a_pc_inc),
    .rx_out(a_rx_out), .rx_in(a_rx_in), .alu_in0(a_alu_in0), .alu_in1(a_alu_in1),
    .alu_out_latch(a_latch), .alu_out_en(a_out_en), .imm_en(a_imm_en), .imm_val(a_imm_val)
  );

  alu_seq #(.NUM_REGS(8), .INSTR_W(16), .IDX_W(6), .SETTLE(3)) u_b (
    .clk(clk), .rst(rst), .start(start), .instruction(instruction),
    .busy(b_busy), .done(b_done), .err(b_err), .pc_inc(b_pc_inc),
    .rx_out(b_rx_out), .rx_in(b_rx_in), .alu_in0(b_alu_in0), .alu_in1(b_alu_in1),
    .alu_out_latch(b_latch), .alu_out_en(b_out_en), .imm_en(b_imm_en), .imm_val(b_imm_val)
  );

  logic [8:0] a_ctl, b_ctl;
  assign a_ctl = {a_busy, a_done, a_err, a_pc_inc, a_alu_in0, a_alu_in1, a_latch, a_out_en, a_imm_en};
  assign b_ctl = {b_busy, b_done, b_err, b_pc_inc, b_alu_in0, b_alu_in1, b_latch, b_out_en, b_imm_en};

  // ctl bit order: busy, done, err, pc_inc, alu_in0, alu_in1, alu_out_latch, alu_out_en, imm_en
  typedef struct packed {
    logic [8:0]  ctl;
    logic [31:0] rxo;
    logic [31:0] rxi;
    logic [5:0]  imm;
  } exp_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected outputs k cycles after the accept edge, straight from the micro-sequence timeline.
  function automatic exp_t model(input int n, input int settle, input logic [15:0] ins, input int k);
    exp_t e;
    int   op, p1, p2, len;
    bit   imm, bad;
    e  = '0;
    op = int'(ins[15:12]);
    p1 = int'(ins[11:6]);
    p2 = int'(ins[5:0]);
    if (op < 8) return e;
    imm = (op == 15);
    bad = (p1 >= n) || (!imm && p2 >= n);
    len = bad ? 1 : 8 + settle;
    if (k > len) return e;
    e.ctl = {1'b1, k == len, bad,
             !bad && k == 1, !bad && k == 2, !bad && k == 5,
             !bad && k >= 6 && k <= 5 + settle,
             !bad && (k == 6 + settle || k == 7 + settle),
             !bad && imm && (k == 4 || k == 5)};
    e.imm = 6'(p2);
    if (!bad) begin
      if (k == 1 || k == 2)                  e.rxo = 32'd1 << (n - 1 - p1);
      else if ((k == 4 || k == 5) && !imm)   e.rxo = 32'd1 << (n - 1 - p2);
      if (k == 7 + settle)                   e.rxi = 32'd1 << (n - 1 - p1);
    end
    return e;
  endfunction

  task automatic cmp_cycle(input logic [15:0] ins, input int k);
    exp_t ea, eb;
    ea = model(4, 1, ins, k);
    eb = model(8, 3, ins, k);
    check($sformatf("A ctl ins=%h k=%0d", ins, k), 32'(a_ctl), 32'(ea.ctl));
    check($sformatf("A rx_out ins=%h k=%0d", ins, k), 32'(a_rx_out), ea.rxo);
    check($sformatf("A rx_in ins=%h k=%0d", ins, k), 32'(a_rx_in), ea.rxi);
    check($sformatf("A imm_val ins=%h k=%0d", ins, k), 32'(a_imm_val), 32'(ea.imm));
    check($sformatf("B ctl ins=%h k=%0d", ins, k), 32'(b_ctl), 32'(eb.ctl));
    check($sformatf("B rx_out ins=%h k=%0d", ins, k), 32'(b_rx_out), eb.rxo);
    check($sformatf("B rx_in ins=%h k=%0d", ins, k), 32'(b_rx_in), eb.rxi);
    check($sformatf("B imm_val ins=%h k=%0d", ins, k), 32'(b_imm_val), 32'(eb.imm));
  endtask

  task automatic check_zero(input string tag);
    check({tag, " A ctl"}, 32'(a_ctl), 32'd0);
    check({tag, " A rx"}, 32'({a_rx_out, a_rx_in}), 32'd0);
    check({tag, " A imm_val"}, 32'(a_imm_val), 32'd0);
    check({tag, " B ctl"}, 32'(b_ctl), 32'd0);
    check({tag, " B rx"}, 32'({b_rx_out, b_rx_in}), 32'd0);
    check({tag, " B imm_val"}, 32'(b_imm_val), 32'd0);
  endtask

  // One request, observed for 12 cycles; noise pulses start with junk while both DUTs are busy.
  task automatic run_txn(input logic [15:0] ins, input bit noise);
    exp_t ea, eb;
    bit   live;
    ea   = model(4, 1, ins, 1);
    eb   = model(8, 3, ins, 1);
    live = noise && ea.ctl[8] && !ea.ctl[6] && eb.ctl[8] && !eb.ctl[6];
    @(negedge clk);
    start       = 1'b1;
    instruction = ins;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      cmp_cycle(ins, k);
      start       = live && (k <= 9) && ($urandom_range(0, 1) == 1);
      instruction = live ? 16'($urandom) : ins;
    end
    start = 1'b0;
  endtask

  initial begin
    logic [3:0]  op;
    logic [5:0]  p1, p2;
    rst         = 1'b1;
    start       = 1'b0;
    instruction = 16'h0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    run_txn(16'h8041, 1'b0);
    run_txn(16'hF0C5, 1'b0);
    run_txn(16'h9107, 1'b0);
    run_txn(16'hA007, 1'b0);
    run_txn(16'h3041, 1'b0);
    run_txn(16'h81C6, 1'b0);
    run_txn(16'h8041, 1'b1);

    // Reset while both DUTs sit in EXEC.
    @(negedge clk);
    start       = 1'b1;
    instruction = 16'hC0C2;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    cmp_cycle(16'hC0C2, 6);
    rst = 1'b1;
    #1;
    check_zero("rst mid-EXEC");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero("after rst release");

    for (int t = 0; t < 40; t++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15));
      p1 = 6'($urandom_range(0, 9));
      p2 = 6'($urandom_range(0, 9));
      run_txn({op, p1, p2}, $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised ALU instruction sequencer for the microcontroller. It supersedes the fixed 4-register ALU control FSM.
- Accepts one ALU-class instruction per start/done handshake.
- Drives one-hot register-file output/input enables, ALU operand/result latch strobes and the PC increment in a fixed micro-sequence, then returns to idle.
- New capabilities: generalised register count, programmable result-settle time, an immediate-operand opcode, and illegal-register error reporting.

Parameters:
- NUM_REGS, 4, number of general registers (2..32); width of rx_out/rx_in.
- INSTR_W, 16, instruction width; opcode = top 4 bits, param1/param2 = next two IDX_W fields.
- IDX_W, 6, register-index / immediate field width; INSTR_W must equal 4+2*IDX_W.
- SETTLE, 1, cycles alu_out_latch is held in EXEC (1..15).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  request; sampled only in IDLE
- instruction  in  INSTR_W  instruction word; captured on accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  qualifies done: illegal register index, no writeback
- pc_inc  out  1  PC increment strobe
- rx_out  out  NUM_REGS  one-hot register output enable; index 0 = MSB
- rx_in  out  NUM_REGS  one-hot register load enable; index 0 = MSB
- alu_in0  out  1  latch bus into ALU operand A
- alu_in1  out  1  latch bus into ALU operand B
- alu_out_latch  out  1  latch ALU result
- alu_out_en  out  1  drive ALU result onto bus
- imm_en  out  1  drive imm_val onto bus (immediate mode)
- imm_val  out  IDX_W  latched param2, zero-extended by datapath

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE; all outputs 0; latched instruction cleared. No partial writeback completes.
- Outputs are a Moore decode of the state register and latched instruction only. No input-to-output combinational path.

Accept rules:
- start is sampled in IDLE only; it is ignored while busy.
- ALU-class opcodes are 4'h8..4'hE (reg-reg) and 4'hF (reg-imm). Any other opcode with start is ignored and the block stays in IDLE.
- On accept the instruction is latched and these checks are made:
  - param1 < NUM_REGS.
  - param2 < NUM_REGS, reg-reg only.
- If any check fails: next state ERR. ERR lasts one cycle with done=1, err=1, pc_inc=0, then IDLE.

Normal sequence, one state per cycle:
- SRC0_DRV: pc_inc=1, rx_out=onehot(param1).
- SRC0_LAT: rx_out=onehot(param1), alu_in0=1.
- GAP: all enables 0 (bus turnaround).
- SRC1_DRV: reg-reg rx_out=onehot(param2); imm imm_en=1.
- SRC1_LAT: same drive as SRC1_DRV, plus alu_in1=1.
- EXEC: alu_out_latch=1, held SETTLE cycles via internal counter.
- OUT_DRV: alu_out_en=1.
- WB: alu_out_en=1, rx_in=onehot(param1).
- DONE: done=1, err=0, then IDLE.

Timing:
- Latency from start-accept edge to the done cycle: 8+SETTLE cycles. With SETTLE=1, done is high in the 9th cycle after the accept edge.
- Back-to-back: start may be high during the DONE cycle, but it is not sampled there. The next accept occurs no earlier than the first IDLE cycle.
- rx_out and rx_in are never both nonzero. At most one bit of each is set.
- imm_en and rx_out are never both nonzero.
- imm_val is valid from accept until IDLE.

Decomposition:
- Package alu_seq_pkg holds:
  - the state enum (IDLE, SRC0_DRV, SRC0_LAT, GAP, SRC1_DRV, SRC1_LAT, EXEC, OUT_DRV, WB, DONE, ERR);
  - the opcode constants OPC_ALU_MIN=4'h8, OPC_ALU_MAX=4'hE, OPC_ALU_IMM=4'hF;
  - the opcode field position.
- Sub-module idx_onehot (params NUM_REGS, IDX_W) maps an index to an MSB-first one-hot vector plus an in_range flag. It is instantiated twice (param1, param2).

Test Plan:
- Reset mid-EXEC: assert rst in EXEC → all outputs 0 immediately. After release, state is IDLE and busy=0.
- NUM_REGS=4, SETTLE=1, instr 16'h8041 (op 8, p1=1, p2=1) → expected response:
  - pc_inc in cycle 1 with rx_out=4'b0100;
  - alu_in0 in cycle 2, alu_in1 in cycle 5;
  - rx_in=4'b0100 in cycle 8;
  - done in cycle 9, err=0.
- Immediate op: instr 16'hF0C5 (p1=3, imm=5) → imm_val=5 and imm_en=1 in cycles 4-5 with rx_out=0; rx_in=4'b0001 in WB; done, err=0.
- Illegal index, NUM_REGS=4: instr 16'h9107 (p1=4) → ERR next cycle: done=1, err=1, pc_inc=0, rx_in never set. Repeat with 16'hA007 (p1=0, p2=7) → same response.
- Ignored requests:
  - start with opcode 4'h3 → busy stays 0, all outputs 0.
  - start pulsed while busy → sequence unaffected, done still at 8+SETTLE.
- Parameter sweep NUM_REGS=8, SETTLE=3, instr p1=7, p2=6 → rx_out=8'b00000001 then 8'b00000010; alu_out_latch high for 3 cycles; done at cycle 11.
